// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline-stage register with synchronous flush and a saturating stall counter.
// Optional feature: define PIPE_STAGE_SKID_EN to add a skid entry and make ready_o registered.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Bit 0 marks the main entry valid, bit 1 the skid entry, so outputs decode straight from flops.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_xfer;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q;

  assign ready_o = ~state_q[1];
`else
  assign ready_o = ~state_q[0] | ready_i;
`endif

  assign valid_o     = state_q[0];
  assign data_o      = data_q;
  assign stall_cnt_o = cnt_q;
  assign in_xfer     = valid_i & ready_o;

  // NOTE: payload flops are reset as well, because data_o must read zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= '0;
`endif
    end else if (flush_i) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop here samples the pre-edge values.
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_q <= ST_FULL;
            data_q  <= data_i;
          end
        end
        ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (ready_i) begin
            if (in_xfer) data_q <= data_i;
            else         state_q <= ST_EMPTY;
          end else if (in_xfer) begin
            state_q <= ST_SKID;
            skid_q  <= data_i;
          end
`else
          // Input can only be taken here while ready_i is high, so this is pass-through.
          if (in_xfer)      data_q  <= data_i;
          else if (ready_i) state_q <= ST_EMPTY;
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_SKID: begin
          if (ready_i) begin
            state_q <= ST_FULL;
            data_q  <= skid_q;
          end
        end
`endif
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  // NOTE: cnt_d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_o && !ready_i && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based model compared every cycle plus directed literal checks.
// Covers both builds; skid-specific expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] data_i = '0;

  logic        ready_o, valid_o;
  logic [31:0] data_o;
  logic [15:0] stall_cnt_o;

  logic        s_ready_o, s_valid_o;
  logic [31:0] s_data_o;
  logic [2:0]  s_stall_cnt_o;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model: entries held by the stage in arrival order, the value data_o must show, and both stall counts.
  logic [31:0] mq[$];
  logic [31:0] m_data = '0;
  int          m_cnt16 = 0;
  int          m_cnt3 = 0;

  pipe_stage_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .flush_i(flush_i),
    .stall_cnt_o(stall_cnt_o)
  );

  pipe_stage_reg #(.DATA_W(32), .CNT_W(3)) dut_s (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(s_ready_o), .data_i(data_i),
    .valid_o(s_valid_o), .ready_i(ready_i), .data_o(s_data_o), .flush_i(flush_i),
    .stall_cnt_o(s_stall_cnt_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || ready_i;
`endif
  endfunction

  task automatic model_step();
    logic take;
    if (!rst_ni) begin
      mq.delete();
      m_data  = '0;
      m_cnt16 = 0;
      m_cnt3  = 0;
      return;
    end
    take = valid_i && exp_ready();
    if (mq.size() != 0 && !ready_i) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt3 < 7)      m_cnt3++;
    end
    if (flush_i) begin
      mq.delete();
      m_data = '0;
    end else begin
      if (mq.size() != 0 && ready_i) void'(mq.pop_front());
      if (take) mq.push_back(data_i);
      if (mq.size() != 0) m_data = mq[0];
    end
  endtask

  initial forever begin
    @(posedge clk_i or negedge rst_ni);
    model_step();
  end

  initial forever begin
    @(negedge clk_i);
    if (chk_en) begin
      check("valid_o", valid_o, mq.size() != 0);
      check("data_o", data_o, m_data);
      check("ready_o", ready_o, exp_ready());
      check("stall_cnt_o", stall_cnt_o, m_cnt16);
      check("s_valid_o", s_valid_o, mq.size() != 0);
      check("s_data_o", s_data_o, m_data);
      check("s_ready_o", s_ready_o, exp_ready());
      check("s_stall_cnt_o", s_stall_cnt_o, m_cnt3);
    end
  end

  // Drive one cycle of inputs at posedge+1 and return at the next posedge+1.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
`ifdef PIPE_STAGE_SKID_EN
    #1;
    ready_i = ~r;
    #1;
    check("ready_o_no_comb", ready_o, exp_ready());
    ready_i = r;
`endif
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid_o", valid_o, 0);
    check("rst_data_o", data_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    check("rst_ready_o", ready_o, 1);
    rst_ni = 1'b1;

    // Streaming at full rate.
    step(1'b1, 32'h1, 1'b1, 1'b0);
    check("stream_d1", data_o, 32'h1);
    check("stream_v1", valid_o, 1);
    step(1'b1, 32'h2, 1'b1, 1'b0);
    check("stream_d2", data_o, 32'h2);
    step(1'b1, 32'h3, 1'b1, 1'b0);
    check("stream_d3", data_o, 32'h3);
    check("stream_v3", valid_o, 1);
    check("stream_stall", stall_cnt_o, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_v", valid_o, 0);
    check("drain_keep_d", data_o, 32'h3);

    // Back-pressure for 4 cycles holding 0xA5.
    step(1'b1, 32'hA5, 1'b1, 1'b0);
    repeat (4) step(1'b1, 32'h5A, 1'b0, 1'b0);
    check("bp_data", data_o, 32'hA5);
    check("bp_stall", stall_cnt_o, 4);
    check("bp_ready", ready_o, 0);
    step(1'b1, 32'h5A, 1'b1, 1'b0);
    check("bp_release_d", data_o, 32'h5A);
    check("bp_release_v", valid_o, 1);
    check("bp_release_rdy", ready_o, 1);
    check("bp_release_stall", stall_cnt_o, 4);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_empty_v", valid_o, 0);

    // Flush with a held entry (and skid entry in the skid build) and a new input.
    step(1'b1, 32'h11, 1'b1, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    check("fl_hold_d", data_o, 32'h11);
    step(1'b1, 32'h33, 1'b0, 1'b1);
    check("fl_v", valid_o, 0);
    check("fl_d", data_o, 32'h0);
    check("fl_stall_kept", stall_cnt_o, 6);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("fl_after_v", valid_o, 0);
    check("fl_after_d", data_o, 32'h0);

    // Flush with the stage empty only zeroes data_o.
    step(1'b1, 32'h44, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("efl_keep_d", data_o, 32'h44);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("efl_d", data_o, 32'h0);
    check("efl_v", valid_o, 0);
    check("efl_stall", stall_cnt_o, 6);

    // Saturation of the 3-bit counter; flush does not clear it.
    step(1'b1, 32'h55, 1'b1, 1'b0);
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b0);
    check("sat_cnt3", s_stall_cnt_o, 7);
    check("sat_cnt16", stall_cnt_o, 16);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("sat_flush_cnt3", s_stall_cnt_o, 7);
    check("sat_flush_cnt16", stall_cnt_o, 17);
    check("sat_flush_v", valid_o, 0);

    // Asynchronous reset between edges while stalled.
    step(1'b1, 32'h66, 1'b1, 1'b0);
    step(1'b1, 32'h77, 1'b0, 1'b0);
    check("ar_pre_stall", stall_cnt_o, 18);
    valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("ar_valid_o", valid_o, 0);
    check("ar_data_o", data_o, 0);
    check("ar_stall", stall_cnt_o, 0);
    check("ar_stall3", s_stall_cnt_o, 0);
    check("ar_ready_o", ready_o, 1);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Random traffic with rare flushes, checked every cycle by the model.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 63) == 0);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("end_drained", valid_o, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register with valid/ready handshake, synchronous flush and an optional skid entry. It is the successor to our fixed-field enable/reset stage registers: any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it with a packed payload. It adds back-pressure, bubble tracking and a stall-cycle counter.

## Interface
- DATA_W, 32: payload width in bits; minimum 1.
- CNT_W, 16: stall-counter width in bits; minimum 1.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- valid_i  in  1  upstream payload valid.
- ready_o  out  1  stage can accept; a transfer occurs on valid_i & ready_o.
- data_i  in  DATA_W  upstream payload.
- valid_o  out  1  downstream payload valid.
- ready_i  in  1  downstream accepts; a transfer occurs on valid_o & ready_i.
- data_o  out  DATA_W  downstream payload, registered.
- flush_i  in  1  synchronous kill of all held entries (branch/hazard flush).
- stall_cnt_o  out  CNT_W  saturating count of cycles with valid_o & ~ready_i.

## Operation
- Reset (rst_ni low, asynchronous): valid_o=0, data_o=0, stall_cnt_o=0, skid entry empty. ready_o=1 during and after reset.
- Main entry (data_o/valid_o):
  - Loads data_i when an input transfer occurs and the main entry is empty or is being drained this cycle.
  - When it empties without a refill, valid_o=0 and data_o keeps its last value.
- flush_i has the highest priority after reset. Next cycle: valid_o=0, data_o=0, skid entry empty.
  - An input presented in the flush cycle is discarded, even if ready_o was 1.
  - A downstream transfer in the flush cycle still counts as completed.
- flush_i with valid_i=0 and the stage empty: no state change except data_o is zeroed.
- Stall counter:
  - Increments when valid_o & ~ready_i.
  - Saturates at all-ones and never wraps.
  - Cleared only by rst_ni; flush_i does not clear it.
- The payload is opaque. The stage never reorders, duplicates or drops an entry, except on flush.

## Timing
- Latency: data_i to data_o is 1 cycle when the stage is empty or draining.
- Without skid (states EMPTY, FULL):
  - ready_o = ~valid_o | ready_i, combinational from ready_i.
  - EMPTY -> FULL on an input transfer.
  - FULL -> FULL on simultaneous input and output transfers (pass-through).
  - FULL -> EMPTY on an output transfer with no input.
  - Any state -> EMPTY on flush_i.
- With skid (states EMPTY, FULL, SKID):
  - ready_o = ~skid_valid, registered, with no combinational path from ready_i.
  - FULL & ~ready_i & input transfer -> SKID; the input is captured in the skid entry.
  - SKID & ready_i -> FULL; the skid entry moves to main the next cycle, and ready_o returns to 1 that cycle.
  - SKID & ~ready_i -> SKID, with ready_o=0.
  - FULL & ready_i & input -> FULL; FULL & ready_i & no input -> EMPTY.
  - EMPTY & input -> FULL.
  - Any state -> EMPTY on flush_i.
- Full throughput is 1 transfer per cycle in both builds under continuous valid_i and ready_i.

## Configuration
- PIPE_STAGE_SKID_EN defined: the skid entry is built, ready_o is registered, and the 3-state machine applies.
- PIPE_STAGE_SKID_EN undefined: no skid storage, ready_o is combinational, and the 2-state machine applies.
- The port list is identical in both builds.

## Test plan
- Reset then stream, DATA_W=32: valid_i=1 with data 0x1,0x2,0x3 and ready_i=1. data_o=0x1,0x2,0x3 on cycles 1,2,3, valid_o=1 throughout, stall_cnt_o=0.
- Back-pressure: hold ready_i=0 for 4 cycles with the stage FULL at 0xA5.
  - data_o stays 0xA5 and stall_cnt_o=4.
  - Skid build: the second input 0x5A is accepted, then ready_o=0. Releasing ready_i delivers 0xA5 then 0x5A.
- Flush: the stage holds 0x11 (plus skid 0x22 in the skid build). Assert flush_i with valid_i=1 and data 0x33. Next cycle valid_o=0 and data_o=0; 0x33 never appears.
- Saturation with CNT_W=3: 10 stall cycles give stall_cnt_o=7. A flush leaves it at 7; rst_ni clears it to 0.
- Asynchronous reset mid-stall: drop rst_ni between clock edges while in SKID/FULL. valid_o=0, data_o=0 and stall_cnt_o=0 immediately, and ready_o=1.
- Random valid_i/ready_i for 10k cycles against a FIFO scoreboard: in-order delivery, no loss or duplication. In the skid build, no combinational path from ready_i to ready_o (checked by toggling ready_i mid-cycle).
